// File: rtl/nclic_core_seq.sv
// Core-side interrupt sequencer for nclic: takes interrupts, keeps the nesting
// stack of return PC and running priority, and handles mret.
module nclic_core_seq #(
  parameter int IntAmount = 8,
  parameter int PrioWidth = 4,
  parameter int PcWidth = 32,
  parameter logic [PcWidth-1:0] VecBase = PcWidth'(32'h0000_0100),
  parameter int StackDepth = 4,
  localparam int IdxWidth = $clog2(IntAmount),
  localparam int DepthWidth = $clog2(StackDepth + 1),
  localparam int SpWidth = $clog2(StackDepth)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_int,
  input  logic [IdxWidth-1:0]   i_idx,
  input  logic [PrioWidth-1:0]  i_prio,
  input  logic                  i_boundary,
  input  logic [PcWidth-1:0]    i_pc,
  input  logic                  i_mret_req,
  output logic                  o_take,
  output logic [PcWidth-1:0]    o_vector,
  output logic [IntAmount-1:0]  o_clr_pend,
  output logic                  o_ret_valid,
  output logic [PcWidth-1:0]    o_ret_pc,
  output logic                  o_mret,
  output logic [PrioWidth-1:0]  o_threshold,
  output logic [DepthWidth-1:0] o_depth,
  output logic                  o_err
);

  typedef enum logic [1:0] {READY, ENTER, LEAVE} state_t;

  state_t state;
  state_t state_next;
  logic accept_int;
  logic accept_mret;
  logic mret_err;
  logic [IdxWidth-1:0] idx;
  logic [PcWidth-1:0] pc_stack [StackDepth];
  logic [PrioWidth-1:0] prio_stack [StackDepth];
  logic [SpWidth-1:0] push_ptr;
  logic [SpWidth-1:0] top_ptr;

  assign push_ptr = SpWidth'(o_depth);
  assign top_ptr  = SpWidth'(o_depth - DepthWidth'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= READY;
    else       state <= state_next;
  end

  // mret outranks an interrupt; ENTER and LEAVE ignore all requests.
  always_comb begin
    state_next  = state;
    accept_int  = 1'b0;
    accept_mret = 1'b0;
    mret_err    = 1'b0;
    case (state)
      READY: begin
        if (i_mret_req && (o_depth != DepthWidth'(0))) begin
          accept_mret = 1'b1;
          state_next  = LEAVE;
        end else if (i_mret_req) begin
          mret_err = 1'b1;
        end else if (i_int && i_boundary && (i_prio > o_threshold) &&
                     (o_depth < DepthWidth'(StackDepth))) begin
          accept_int = 1'b1;
          state_next = ENTER;
        end else begin
          state_next = READY;
        end
      end
      default: state_next = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept_int) begin
      pc_stack[push_ptr]   <= i_pc;
      prio_stack[push_ptr] <= o_threshold;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_threshold <= '0;
      o_depth     <= '0;
      o_err       <= 1'b0;
      o_vector    <= '0;
      o_ret_pc    <= '0;
      idx         <= '0;
    end else begin
      if (accept_int) begin
        o_threshold <= i_prio;
        o_depth     <= o_depth + DepthWidth'(1);
        idx         <= i_idx;
        o_vector    <= VecBase + PcWidth'({i_idx, 2'b00});
      end else if (accept_mret) begin
        o_threshold <= (o_depth == DepthWidth'(1)) ? '0 : prio_stack[top_ptr];
        o_depth     <= o_depth - DepthWidth'(1);
        o_ret_pc    <= pc_stack[top_ptr];
      end
      if (mret_err) o_err <= 1'b1;
    end
  end

  // Strobes are suppressed in the very cycle reset is asserted.
  assign o_take      = (state == ENTER) && !reset;
  assign o_clr_pend  = o_take ? (IntAmount'(1) << idx) : '0;
  assign o_ret_valid = (state == LEAVE) && !reset;
  assign o_mret      = o_ret_valid;

endmodule

// File: tb/tb_nclic_core_seq.sv
// Self-checking bench for nclic_core_seq: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_nclic_core_seq;
  logic clk = 1'b0;
  logic reset;
  logic i_int, i_boundary, i_mret_req;
  logic [2:0] i_idx;
  logic [3:0] i_prio;
  logic [31:0] i_pc;
  logic o_take, o_ret_valid, o_mret, o_err;
  logic [31:0] o_vector, o_ret_pc;
  logic [7:0] o_clr_pend;
  logic [3:0] o_threshold;
  logic [2:0] o_depth;

  int n_tests = 0;
  int n_fail = 0;

  nclic_core_seq dut (
    .clk(clk), .reset(reset), .i_int(i_int), .i_idx(i_idx), .i_prio(i_prio),
    .i_boundary(i_boundary), .i_pc(i_pc), .i_mret_req(i_mret_req),
    .o_take(o_take), .o_vector(o_vector), .o_clr_pend(o_clr_pend),
    .o_ret_valid(o_ret_valid), .o_ret_pc(o_ret_pc), .o_mret(o_mret),
    .o_threshold(o_threshold), .o_depth(o_depth), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_int = 1'b0; i_boundary = 1'b0; i_mret_req = 1'b0;
    i_idx = 3'd0; i_prio = 4'd0; i_pc = 32'd0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic req(input logic [2:0] idx, input logic [3:0] prio, input logic [31:0] pc);
    i_int = 1'b1; i_boundary = 1'b1; i_idx = idx; i_prio = prio; i_pc = pc;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({o_take, o_vector, o_clr_pend, o_ret_valid, o_ret_pc, o_mret, o_threshold, o_depth, o_err} !== 85'd0) begin
      n_fail++; $display("FAIL reset_outputs: got take=%b vec=%h clr=%h rv=%b rpc=%h mret=%b thr=%0d dep=%0d err=%b, want all 0",
        o_take, o_vector, o_clr_pend, o_ret_valid, o_ret_pc, o_mret, o_threshold, o_depth, o_err);
    end
  endtask

  task automatic test_entry();
    req(3'd5, 4'd2, 32'h400);
    tick();
    n_tests++;
    if ({o_take, o_vector, o_clr_pend, o_threshold, o_depth} !== {1'b1, 32'h114, 8'b0010_0000, 4'd2, 3'd1}) begin
      n_fail++; $display("FAIL entry: got take=%b vec=%h clr=%b thr=%0d dep=%0d, want 1 114 00100000 2 1",
        o_take, o_vector, o_clr_pend, o_threshold, o_depth);
    end
    idle();
    tick();
    n_tests++;
    if ({o_take, o_clr_pend, o_vector} !== {1'b0, 8'd0, 32'h114}) begin
      n_fail++; $display("FAIL entry_hold: got take=%b clr=%h vec=%h, want 0 00 114", o_take, o_clr_pend, o_vector);
    end
  endtask

  task automatic test_nesting();
    req(3'd1, 4'd3, 32'h500);
    tick();
    n_tests++;
    if ({o_take, o_vector, o_depth, o_threshold} !== {1'b1, 32'h104, 3'd2, 4'd3}) begin
      n_fail++; $display("FAIL nest_take: got take=%b vec=%h dep=%0d thr=%0d, want 1 104 2 3", o_take, o_vector, o_depth, o_threshold);
    end
    idle();
    tick();
    req(3'd6, 4'd3, 32'h600);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if ({o_take, o_depth} !== {1'b0, 3'd2}) begin
        n_fail++; $display("FAIL equal_prio_blocked: cycle %0d got take=%b dep=%0d, want 0 2", c, o_take, o_depth);
      end
    end
    idle();
    i_mret_req = 1'b1;
    tick();
    n_tests++;
    if ({o_ret_valid, o_mret, o_ret_pc, o_threshold, o_depth} !== {1'b1, 1'b1, 32'h500, 4'd2, 3'd1}) begin
      n_fail++; $display("FAIL mret1: got rv=%b mret=%b rpc=%h thr=%0d dep=%0d, want 1 1 500 2 1",
        o_ret_valid, o_mret, o_ret_pc, o_threshold, o_depth);
    end
    i_mret_req = 1'b0;
    tick();
    n_tests++;
    if ({o_ret_valid, o_mret, o_ret_pc} !== {1'b0, 1'b0, 32'h500}) begin
      n_fail++; $display("FAIL mret1_end: got rv=%b mret=%b rpc=%h, want 0 0 500", o_ret_valid, o_mret, o_ret_pc);
    end
    i_mret_req = 1'b1;
    tick();
    n_tests++;
    if ({o_ret_valid, o_mret, o_ret_pc, o_threshold, o_depth} !== {1'b1, 1'b1, 32'h400, 4'd0, 3'd0}) begin
      n_fail++; $display("FAIL mret2: got rv=%b mret=%b rpc=%h thr=%0d dep=%0d, want 1 1 400 0 0",
        o_ret_valid, o_mret, o_ret_pc, o_threshold, o_depth);
    end
    idle();
    tick();
  endtask

  task automatic test_full_stack();
    do_reset();
    for (int p = 1; p <= 4; p++) begin
      req(3'(p), 4'(p), 32'h1000 + 32'(p * 16));
      tick();
      idle();
      tick();
    end
    n_tests++;
    if ({o_depth, o_threshold} !== {3'd4, 4'd4}) begin
      n_fail++; $display("FAIL fill: got dep=%0d thr=%0d, want 4 4", o_depth, o_threshold);
    end
    req(3'd7, 4'd9, 32'h2000);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if ({o_take, o_err, o_depth} !== {1'b0, 1'b0, 3'd4}) begin
        n_fail++; $display("FAIL full_blocked: cycle %0d got take=%b err=%b dep=%0d, want 0 0 4", c, o_take, o_err, o_depth);
      end
    end
    i_mret_req = 1'b1;
    tick();
    n_tests++;
    if ({o_mret, o_take, o_ret_pc, o_threshold, o_depth} !== {1'b1, 1'b0, 32'h1040, 4'd3, 3'd3}) begin
      n_fail++; $display("FAIL full_mret: got mret=%b take=%b rpc=%h thr=%0d dep=%0d, want 1 0 1040 3 3",
        o_mret, o_take, o_ret_pc, o_threshold, o_depth);
    end
    i_mret_req = 1'b0;
    tick();
    n_tests++;
    if (o_take !== 1'b0) begin
      n_fail++; $display("FAIL full_chain_gap: got take=%b, want 0", o_take);
    end
    tick();
    n_tests++;
    if ({o_take, o_vector, o_threshold, o_depth} !== {1'b1, 32'h11C, 4'd9, 3'd4}) begin
      n_fail++; $display("FAIL full_chain_take: got take=%b vec=%h thr=%0d dep=%0d, want 1 11c 9 4", o_take, o_vector, o_threshold, o_depth);
    end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req(3'd0, 4'd2, 32'h40);
    tick();
    idle();
    tick();
    req(3'd3, 4'd5, 32'h80);
    i_mret_req = 1'b1;
    tick();
    n_tests++;
    if ({o_mret, o_take, o_ret_pc, o_threshold, o_depth} !== {1'b1, 1'b0, 32'h40, 4'd0, 3'd0}) begin
      n_fail++; $display("FAIL b2b_mret: got mret=%b take=%b rpc=%h thr=%0d dep=%0d, want 1 0 40 0 0",
        o_mret, o_take, o_ret_pc, o_threshold, o_depth);
    end
    i_mret_req = 1'b0;
    tick();
    n_tests++;
    if ({o_take, o_mret} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_gap: got take=%b mret=%b, want 0 0", o_take, o_mret);
    end
    tick();
    n_tests++;
    if ({o_take, o_vector, o_clr_pend, o_threshold, o_depth} !== {1'b1, 32'h10C, 8'b0000_1000, 4'd5, 3'd1}) begin
      n_fail++; $display("FAIL b2b_take: got take=%b vec=%h clr=%b thr=%0d dep=%0d, want 1 10c 00001000 5 1",
        o_take, o_vector, o_clr_pend, o_threshold, o_depth);
    end
    idle();
    tick();
  endtask

  task automatic test_mret_err();
    do_reset();
    i_mret_req = 1'b1;
    tick();
    n_tests++;
    if ({o_ret_valid, o_mret, o_err, o_depth} !== {1'b0, 1'b0, 1'b1, 3'd0}) begin
      n_fail++; $display("FAIL mret_err: got rv=%b mret=%b err=%b dep=%0d, want 0 0 1 0", o_ret_valid, o_mret, o_err, o_depth);
    end
    i_mret_req = 1'b0;
    req(3'd2, 4'd1, 32'h10);
    tick();
    idle();
    repeat (3) tick();
    n_tests++;
    if (o_err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: got err=%b, want 1", o_err);
    end
    do_reset();
    n_tests++;
    if (o_err !== 1'b0) begin
      n_fail++; $display("FAIL err_cleared: got err=%b, want 0", o_err);
    end
  endtask

  task automatic test_reset_during_enter();
    do_reset();
    req(3'd2, 4'd6, 32'h900);
    tick();
    n_tests++;
    if (o_take !== 1'b1) begin
      n_fail++; $display("FAIL rst_enter_pre: got take=%b, want 1", o_take);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({o_take, o_clr_pend} !== 9'd0) begin
      n_fail++; $display("FAIL rst_enter_same: got take=%b clr=%h, want 0 00", o_take, o_clr_pend);
    end
    idle();
    tick();
    n_tests++;
    if ({o_take, o_vector, o_clr_pend, o_ret_valid, o_ret_pc, o_mret, o_threshold, o_depth, o_err} !== 85'd0) begin
      n_fail++; $display("FAIL rst_enter_after: got take=%b vec=%h clr=%h thr=%0d dep=%0d err=%b, want all 0",
        o_take, o_vector, o_clr_pend, o_threshold, o_depth, o_err);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] q_pc[$];
    logic [3:0] q_pr[$];
    logic [3:0] m_thr;
    logic [31:0] m_vec, m_retpc;
    logic [2:0] m_idx;
    logic [7:0] one;
    logic [7:0] exp_clr;
    logic m_err;
    int m_phase;
    do_reset();
    m_thr = 4'd0; m_vec = 32'd0; m_retpc = 32'd0; m_idx = 3'd0; m_err = 1'b0; m_phase = 0;
    one = 8'd1;
    for (int c = 0; c < 600; c++) begin
      i_int = 1'($urandom_range(0, 1));
      i_boundary = ($urandom_range(0, 3) != 0);
      i_idx = 3'($urandom_range(0, 7));
      i_prio = 4'($urandom_range(0, 15));
      i_pc = $urandom;
      i_mret_req = ($urandom_range(0, 99) < 18);
      if (m_phase != 0) begin
        m_phase = 0;
      end else if (i_mret_req && q_pc.size() > 0) begin
        m_retpc = q_pc.pop_back();
        m_thr = q_pr.pop_back();
        m_phase = 2;
      end else if (i_mret_req) begin
        m_err = 1'b1;
      end else if (i_int && i_boundary && i_prio > m_thr && q_pc.size() < 4) begin
        q_pc.push_back(i_pc);
        q_pr.push_back(m_thr);
        m_thr = i_prio;
        m_idx = i_idx;
        m_vec = 32'h100 + 32'(i_idx) * 32'd4;
        m_phase = 1;
      end
      tick();
      exp_clr = (m_phase == 1) ? (one << m_idx) : 8'd0;
      n_tests++;
      if ({o_take, o_vector, o_clr_pend, o_ret_valid, o_ret_pc, o_mret, o_threshold, o_depth, o_err} !==
          {(m_phase == 1), m_vec, exp_clr, (m_phase == 2), m_retpc, (m_phase == 2), m_thr, 3'(q_pc.size()), m_err}) begin
        n_fail++;
        $display("FAIL random c%0d: got take=%b vec=%h clr=%h rv=%b rpc=%h mret=%b thr=%0d dep=%0d err=%b, want %b %h %h %b %h %b %0d %0d %b",
          c, o_take, o_vector, o_clr_pend, o_ret_valid, o_ret_pc, o_mret, o_threshold, o_depth, o_err,
          (m_phase == 1), m_vec, exp_clr, (m_phase == 2), m_retpc, (m_phase == 2), m_thr, q_pc.size(), m_err);
      end
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_entry();
    test_nesting();
    test_full_stack();
    test_back_to_back();
    test_mret_err();
    test_reset_during_enter();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/nclic_core_seq.md
Name: nclic_core_seq

Overview:
- Core-side counterpart of the nclic controller. Consumes the controller's interrupt request (o_int/o_idx/o_prio) and decides whether to take it.
- On entry: pushes the return PC and the running priority onto a hardware stack, redirects the core to a vector address, and clears the serviced pending bit.
- On mret: pops the stack, restores PC and priority, and pulses mret back to the controller.
- Sits between nclic and the core fetch/PC logic.

Parameters:
- IntAmount, 8, number of interrupt lines.
- PrioWidth, 4, width of a priority value (unsigned). 0 means thread level.
- PcWidth, 32, width of a PC.
- VecBase, 32'h0000_0100, vector table base; one 4-byte slot per interrupt.
- StackDepth, 4, maximum nesting depth (entries).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- i_int  in  1  interrupt request from nclic.
- i_idx  in  $clog2(IntAmount)  requesting interrupt index.
- i_prio  in  PrioWidth  requesting interrupt priority.
- i_boundary  in  1  core is at an instruction boundary and may be redirected.
- i_pc  in  PcWidth  PC of the next instruction (the return address if taken now).
- i_mret_req  in  1  core is retiring an mret instruction.
- o_take  out  1  one-cycle pulse: core must jump to o_vector.
- o_vector  out  PcWidth  VecBase + 4*idx of the taken interrupt.
- o_clr_pend  out  IntAmount  one-hot, one-cycle pulse clearing the serviced pending bit.
- o_ret_valid  out  1  one-cycle pulse: core must jump to o_ret_pc.
- o_ret_pc  out  PcWidth  popped return PC.
- o_mret  out  1  one-cycle pulse to nclic (mret input).
- o_threshold  out  PrioWidth  current running priority.
- o_depth  out  $clog2(StackDepth+1)  current nesting depth.
- o_err  out  1  sticky error flag.

Behaviour:
- Reset values: all outputs 0; state READY; stack contents don't-care. Reset asserted in any state aborts the operation in progress, with no pulses in that cycle or after.
- States: READY, ENTER, LEAVE. ENTER and LEAVE each last exactly one cycle and always return to READY.
- READY, checked in priority order:
  1. i_mret_req && depth>0 -> LEAVE.
  2. i_mret_req && depth==0 -> o_err<=1; stay READY; no pulses.
  3. i_int && i_boundary && i_prio>o_threshold (strict unsigned compare) && depth<StackDepth -> ENTER. At the accepting edge:
     - push {i_pc, o_threshold};
     - o_threshold<=i_prio;
     - depth++;
     - latch i_idx.
  4. Otherwise stay READY.
- mret wins over a simultaneous interrupt. The interrupt is re-evaluated in READY after LEAVE (tail-chain), so it is taken at the earliest 2 cycles after mret.
- Priority gating:
  - i_prio <= o_threshold is never taken (equal priority does not preempt).
  - depth==StackDepth blocks entry silently. No error; the request stays pending in nclic.
  - i_int without i_boundary is held off; nothing is latched.
- ENTER cycle (the cycle after acceptance):
  - o_take=1.
  - o_vector = VecBase + {latched idx, 2'b00}, zero-extended to PcWidth, modulo 2^PcWidth.
  - o_clr_pend = 1<<latched idx.
  - In this cycle i_mret_req and i_int are ignored.
- LEAVE cycle (the cycle after mret acceptance):
  - o_ret_valid=1; o_ret_pc = top PC; o_mret=1.
  - o_threshold restored to the top saved priority; depth--.
  - Popping the last entry restores o_threshold to 0.
- o_vector and o_ret_pc are held stable (last value) when their strobes are low.
- o_err is cleared only by reset.
- Latency: request accepted at edge N; o_take/o_clr_pend valid in cycle N..N+1; new threshold visible from edge N.

Test Plan:
- Reset, depth 0. Drive i_int=1, i_idx=5, i_prio=2, i_boundary=1, i_pc=0x400 -> next cycle o_take=1, o_vector=0x114, o_clr_pend=8'b0010_0000, o_threshold=2, o_depth=1.
- Nesting: while at prio 2, request idx=1 prio=3 with i_pc=0x500 -> taken, o_vector=0x104, depth=2. Then idx=6 prio=3 -> not taken (equal priority). Then mret -> o_ret_pc=0x500, o_mret pulse, o_threshold=2. Second mret -> o_ret_pc=0x400, threshold=0, depth=0.
- Fill the stack with 4 nested entries at prios 1,2,3,4 (PrioWidth=4) -> a request at prio 9 is blocked, with no o_take and o_err=0. Then mret -> a prio-9 request is taken 2 cycles later.
- Same-cycle i_mret_req and i_int (prio higher than the restored level) at depth 1 -> o_mret first, o_take exactly 2 cycles later.
- mret at depth 0 -> no pulses; o_err=1 and stays 1 until reset.
- Assert reset during ENTER -> o_take deasserted that cycle; all outputs 0 the next cycle; depth 0.
